// File: rtl/ppu_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e   : controller states (run, waiting on data memory, timeout trap)
//   FWD_*     : EX operand-select encodings
//   PC_REG    : register number of the PC, never a hazard source or forward target
package ppu_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StTrap    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding comparator for one EX source operand.
// Ports:
//   src            : source register of the instruction now in EX
//   mem_we/mem_rd  : EX/MEM write-back candidate
//   wb_we/wb_rd    : MEM/WB write-back candidate
//   sel            : FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_unit
  import ppu_pkg::*;
#(
  parameter int unsigned RW = 4
) (
  input  logic [RW-1:0] src,
  input  logic          mem_we,
  input  logic [RW-1:0] mem_rd,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  output logic [1:0]    sel
);

  logic src_is_pc;

  assign src_is_pc = (src == RW'(PC_REG));

  // The younger result (EX/MEM) takes precedence over MEM/WB.
  always_comb begin
    sel = FWD_RF;
    if (!src_is_pc) begin
      if (mem_we && (mem_rd == src)) begin
        sel = FWD_EXMEM;
      end else if (wb_we && (wb_rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Ports:
//   clk, Reset                    : clock (rising edge), async active-high reset
//   id_rn/id_rm, id_use_rn/rm     : ID-stage sources and their use flags
//   ex_rn/ex_rm                   : registered sources of the instruction in EX
//   ex_rd/mem_rd/wb_rd, *_we      : destinations and write-enables per stage
//   ex_load, ex_branch_taken      : EX-stage load / taken-branch flags
//   mem_req, mem_rdy              : data-memory handshake
//   *_ld                          : stage-register load enables
//   ifid_flush/idex_nop/memwb_nop : bubble insertion
//   pc_src_br                     : PC takes branch target
//   fwd_a/fwd_b                   : EX operand forwarding selects
//   stall_cnt                     : saturating count of cycles with pc_ld low
//   mem_err                       : sticky memory-timeout trap
module pipe_hazard_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned RW          = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [RW-1:0]    id_rn,
  input  logic [RW-1:0]    id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [RW-1:0]    ex_rn,
  input  logic [RW-1:0]    ex_rm,
  input  logic [RW-1:0]    ex_rd,
  input  logic [RW-1:0]    mem_rd,
  input  logic [RW-1:0]    wb_rd,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_rdy,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             idex_ld,
  output logic             exmem_ld,
  output logic             memwb_ld,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic             memwb_nop,
  output logic             pc_src_br,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [WaitW-1:0]   wait_inc;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_err_q, mem_err_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       load_use, mem_stall, ex_rd_is_pc;
  logic       run_eval, freeze;

  fwd_unit #(.RW(RW)) u_fwd_a (
    .src    (ex_rn),
    .mem_we (mem_we),
    .mem_rd (mem_rd),
    .wb_we  (wb_we),
    .wb_rd  (wb_rd),
    .sel    (fwd_a_raw)
  );

  fwd_unit #(.RW(RW)) u_fwd_b (
    .src    (ex_rm),
    .mem_we (mem_we),
    .mem_rd (mem_rd),
    .wb_we  (wb_we),
    .wb_rd  (wb_rd),
    .sel    (fwd_b_raw)
  );

  assign ex_rd_is_pc = (ex_rd == RW'(PC_REG));
  assign load_use    = ex_load && ex_we && !ex_rd_is_pc &&
                       ((id_use_rn && (ex_rd == id_rn)) || (id_use_rm && (ex_rd == id_rm)));
  assign mem_stall   = mem_req && !mem_rdy;
  assign wait_inc    = wait_q + WaitW'(1);

  // Next state and wait counter.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    run_eval = 1'b0;
    freeze   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          freeze  = 1'b1;
          wait_d  = WaitW'(1);
          state_d = (MEM_TIMEOUT <= 1) ? StTrap : StMemWait;
        end else begin
          run_eval = 1'b1;
        end
      end
      StMemWait: begin
        if (mem_rdy) begin
          // Release in the same cycle the access completes.
          run_eval = 1'b1;
          wait_d   = '0;
          state_d  = StRun;
        end else begin
          freeze = 1'b1;
          wait_d = wait_inc;
          if (wait_inc >= WaitW'(MEM_TIMEOUT)) begin
            state_d = StTrap;
          end
        end
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  // Control outputs; everything is held inactive while Reset is high.
  always_comb begin
    pc_ld      = 1'b0;
    ifid_ld    = 1'b0;
    idex_ld    = 1'b0;
    exmem_ld   = 1'b0;
    memwb_ld   = 1'b0;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    memwb_nop  = 1'b0;
    pc_src_br  = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    if (!Reset) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (freeze) begin
        memwb_nop = 1'b1;
      end else if (run_eval) begin
        pc_ld    = 1'b1;
        ifid_ld  = 1'b1;
        idex_ld  = 1'b1;
        exmem_ld = 1'b1;
        memwb_ld = 1'b1;
        if (ex_branch_taken) begin
          // Flushing the wrong-path instructions also kills any load-use hazard.
          pc_src_br  = 1'b1;
          ifid_flush = 1'b1;
          idex_nop   = 1'b1;
        end else if (load_use) begin
          pc_ld    = 1'b0;
          ifid_ld  = 1'b0;
          idex_nop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_ld && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    mem_err_d = mem_err_q || (state_d == StTrap);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StRun;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, with expectations queued on drive and
// compared at the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RW    = 4;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [3:0] id_rn;
    logic [3:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [3:0] ex_rn;
    logic [3:0] ex_rm;
    logic [3:0] ex_rd;
    logic [3:0] mem_rd;
    logic [3:0] wb_rd;
    logic       ex_we;
    logic       mem_we;
    logic       wb_we;
    logic       ex_load;
    logic       br;
    logic       mem_req;
    logic       mem_rdy;
  } in_t;

  typedef struct packed {
    logic [4:0] ld;   // pc, ifid, idex, exmem, memwb
    logic [2:0] bub;  // ifid_flush, idex_nop, memwb_nop
    logic       br;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic             clk, Reset;
  logic [RW-1:0]    id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
  logic             id_use_rn, id_use_rm, ex_we, mem_we, wb_we;
  logic             ex_load, ex_branch_taken, mem_req, mem_rdy;
  logic             pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
  logic             ifid_flush, idex_nop, memwb_nop, pc_src_br, mem_err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  pipe_hazard_ctrl #(.RW(RW), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .Reset           (Reset),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_use_rn       (id_use_rn),
    .id_use_rm       (id_use_rm),
    .ex_rn           (ex_rn),
    .ex_rm           (ex_rm),
    .ex_rd           (ex_rd),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .ex_we           (ex_we),
    .mem_we          (mem_we),
    .wb_we           (wb_we),
    .ex_load         (ex_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_rdy         (mem_rdy),
    .pc_ld           (pc_ld),
    .ifid_ld         (ifid_ld),
    .idex_ld         (idex_ld),
    .exmem_ld        (exmem_ld),
    .memwb_ld        (memwb_ld),
    .ifid_flush      (ifid_flush),
    .idex_nop        (idex_nop),
    .memwb_nop       (memwb_nop),
    .pc_src_br       (pc_src_br),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt),
    .mem_err         (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mke(logic [4:0] ld, logic [2:0] bub, logic br,
                               logic [1:0] fa, logic [1:0] fb, logic err);
    exp_t e;
    e.ld = ld; e.bub = bub; e.br = br; e.fa = fa; e.fb = fb; e.err = err;
    return e;
  endfunction

  task automatic apply(input in_t i);
    id_rn = i.id_rn; id_rm = i.id_rm; id_use_rn = i.id_use_rn; id_use_rm = i.id_use_rm;
    ex_rn = i.ex_rn; ex_rm = i.ex_rm; ex_rd = i.ex_rd; mem_rd = i.mem_rd; wb_rd = i.wb_rd;
    ex_we = i.ex_we; mem_we = i.mem_we; wb_we = i.wb_we; ex_load = i.ex_load;
    ex_branch_taken = i.br; mem_req = i.mem_req; mem_rdy = i.mem_rdy;
  endtask

  task automatic cmp(input string tag, input string what, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s: got %0h, required %0h", tag, what, act, req);
    end
  endtask

  // Pops the oldest expectation and compares every output against it.
  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp(tag, "scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "ld",        int'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), int'(e.ld));
    cmp(tag, "bubbles",   int'({ifid_flush, idex_nop, memwb_nop}), int'(e.bub));
    cmp(tag, "pc_src_br", int'(pc_src_br), int'(e.br));
    cmp(tag, "fwd_a",     int'(fwd_a), int'(e.fa));
    cmp(tag, "fwd_b",     int'(fwd_b), int'(e.fb));
    cmp(tag, "mem_err",   int'(mem_err), int'(e.err));
    cmp(tag, "stall_cnt", int'(stall_cnt), model_cnt);
    // Counter updates at the next rising edge when pc_ld was low this cycle.
    if (!Reset && !e.ld[4] && model_cnt < (2 ** CNT_W - 1)) model_cnt++;
  endtask

  // One clock cycle: drive just after the rising edge, compare at the falling edge.
  task automatic cycle(input in_t i, input exp_t e, input string tag);
    apply(i);
    sb.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    in_t z;
    z = '0;
    apply(z);
    Reset = 1'b1;
    #1;
    model_cnt = 0;
    sb.push_back(mke(5'b00000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0));
    check(tag);
    Reset = 1'b0;
    #1;
  endtask

  exp_t e_run, e_lu, e_br, e_frz, e_trap;
  in_t  t, idle, stall;

  initial begin
    e_run  = mke(5'b11111, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
    e_lu   = mke(5'b00111, 3'b010, 1'b0, 2'b00, 2'b00, 1'b0);
    e_br   = mke(5'b11111, 3'b110, 1'b1, 2'b00, 2'b00, 1'b0);
    e_frz  = mke(5'b00000, 3'b001, 1'b0, 2'b00, 2'b00, 1'b0);
    e_trap = mke(5'b00000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b1);
    idle   = '0;
    stall  = '0; stall.mem_req = 1'b1;

    // Single-cycle vectors, all starting and ending in RUN.
    vecs.push_back('{i: idle, e: e_run});
    t = '0; t.mem_we = 1; t.mem_rd = 2; t.wb_we = 1; t.wb_rd = 2; t.ex_rn = 2; t.ex_rm = 5;
    vecs.push_back('{i: t, e: mke(5'b11111, 3'b000, 1'b0, 2'b01, 2'b00, 1'b0)});
    t.mem_rd = 15;
    vecs.push_back('{i: t, e: mke(5'b11111, 3'b000, 1'b0, 2'b10, 2'b00, 1'b0)});
    t = '0; t.wb_we = 1; t.wb_rd = 7; t.ex_rm = 7; t.ex_rn = 1;
    vecs.push_back('{i: t, e: mke(5'b11111, 3'b000, 1'b0, 2'b00, 2'b10, 1'b0)});
    t = '0; t.mem_we = 1; t.mem_rd = 15; t.wb_we = 1; t.wb_rd = 15; t.ex_rn = 15; t.ex_rm = 15;
    vecs.push_back('{i: t, e: e_run});
    t = '0; t.mem_we = 0; t.mem_rd = 9; t.wb_we = 1; t.wb_rd = 9; t.ex_rn = 9; t.ex_rm = 9;
    vecs.push_back('{i: t, e: mke(5'b11111, 3'b000, 1'b0, 2'b10, 2'b10, 1'b0)});
    t = '0; t.mem_we = 1; t.mem_rd = 4; t.ex_rn = 3; t.ex_rm = 4;
    vecs.push_back('{i: t, e: mke(5'b11111, 3'b000, 1'b0, 2'b00, 2'b01, 1'b0)});
    t = '0; t.br = 1; t.ex_load = 1; t.ex_we = 1; t.ex_rd = 3; t.id_rn = 3; t.id_use_rn = 1;
    vecs.push_back('{i: t, e: e_br});
    t.br = 0; t.id_use_rn = 0;
    vecs.push_back('{i: t, e: e_run});
    t = '0; t.ex_load = 1; t.ex_we = 1; t.ex_rd = 4; t.id_rm = 4; t.id_use_rm = 1; t.id_rn = 1;
    vecs.push_back('{i: t, e: e_lu});
    t = '0; t.ex_load = 1; t.ex_we = 1; t.ex_rd = 15; t.id_rn = 15; t.id_use_rn = 1;
    vecs.push_back('{i: t, e: e_run});
    t = '0; t.ex_load = 1; t.ex_we = 0; t.ex_rd = 6; t.id_rn = 6; t.id_use_rn = 1;
    vecs.push_back('{i: t, e: e_run});
    t = '0; t.ex_load = 0; t.ex_we = 1; t.ex_rd = 6; t.id_rn = 6; t.id_use_rn = 1;
    vecs.push_back('{i: t, e: e_run});
    t = '0; t.mem_req = 1; t.mem_rdy = 1;
    vecs.push_back('{i: t, e: e_run});
    vecs.push_back('{i: idle, e: e_run});

    // Reset from t=0; outputs must be inactive even with forwarding inputs matching.
    Reset = 1'b1;
    t = '0; t.mem_we = 1; t.mem_rd = 2; t.ex_rn = 2; t.ex_load = 1; t.ex_we = 1;
    apply(t);
    #1;
    sb.push_back(mke(5'b00000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0));
    check("reset");
    Reset = 1'b0;
    apply(idle);
    @(posedge clk);
    #1;
    cycle(idle, e_run, "first");

    // Load-use: exactly one bubble, then normal flow.
    t = '0; t.ex_load = 1; t.ex_we = 1; t.ex_rd = 3; t.id_rn = 3; t.id_use_rn = 1;
    cycle(t, e_lu, "lu_stall");
    cycle(idle, e_run, "lu_after");
    cycle(idle, e_run, "lu_cnt");

    foreach (vecs[k]) cycle(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));

    // Memory wait for 3 cycles; a branch on the first is ignored, one on release is taken.
    t = stall; t.br = 1;
    cycle(t, e_frz, "mw_enter");
    t = stall; t.mem_we = 1; t.mem_rd = 6; t.ex_rn = 6;
    cycle(t, mke(5'b00000, 3'b001, 1'b0, 2'b01, 2'b00, 1'b0), "mw_wait1");
    cycle(stall, e_frz, "mw_wait2");
    t = stall; t.mem_rdy = 1; t.br = 1;
    cycle(t, e_br, "mw_release");
    cycle(idle, e_run, "mw_after");

    // Reset in the middle of a wait returns straight to RUN.
    cycle(stall, e_frz, "mr_enter");
    cycle(stall, e_frz, "mr_wait");
    async_reset("mr_reset");
    cycle(idle, e_run, "mr_after");

    // Timeout: 15 frozen cycles, trap on the 16th, held even when memory answers.
    for (int k = 1; k <= 15; k++) cycle(stall, e_frz, $sformatf("to_frz%0d", k));
    cycle(stall, e_trap, "to_trap16");
    t = stall; t.mem_rdy = 1; t.br = 1;
    cycle(t, e_trap, "to_hold1");
    cycle(idle, e_trap, "to_hold2");
    async_reset("to_reset");
    cycle(idle, e_run, "to_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage pipelined processor (IF, ID, EX, MEM, WB). It decides every cycle which pipeline registers load, which stages receive a bubble, and which operand forwarding paths EX uses. It also runs a memory-wait state machine that freezes the pipeline while data memory is busy, and a sticky error trap for memory timeouts. It sits beside the datapath in `main` and drives every stage-register enable.

## Interface
- `RW`, default 4: register-number width (16 architectural registers).
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles before trapping.
- `CNT_W`, default 16: width of the stall performance counter.

- `clk`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `id_rn`, `id_rm`  in  RW  ID-stage source registers.
- `id_use_rn`, `id_use_rm`  in  1  ID instruction actually reads `id_rn` / `id_rm`.
- `ex_rd`, `mem_rd`, `wb_rd`  in  RW  destination registers in EX, MEM and WB.
- `ex_we`, `mem_we`, `wb_we`  in  1  register write-enables in EX, MEM and WB.
- `ex_load`  in  1  EX instruction is a load.
- `ex_branch_taken`  in  1  branch resolved taken in EX.
- `mem_req`  in  1  MEM stage is accessing data memory.
- `mem_rdy`  in  1  data memory completes the access this cycle.
- `pc_ld`, `ifid_ld`, `idex_ld`, `exmem_ld`, `memwb_ld`  out  1  stage-register load enables.
- `ifid_flush`, `idex_nop`, `memwb_nop`  out  1  insert a bubble into that register.
- `pc_src_br`  out  1  select the branch target for the PC.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_ld` = 0.
- `mem_err`  out  1  sticky memory-timeout trap.

## Operation
- States: RUN, MEM_WAIT, TRAP. Register number 15 (PC) is never a hazard source or a forwarding target.
- Forwarding is purely combinational and valid in every state.
  - `fwd_a` = 01 if `mem_we` and `mem_rd` == `id_rn` of the instruction now in EX. This is the registered copy, exposed as inputs `ex_rn`/`ex_rm` (RW each); the implementation adds these two ports.
  - Otherwise `fwd_a` = 10 if `wb_we` and `wb_rd` matches.
  - Otherwise `fwd_a` = 00. EX/MEM wins over MEM/WB. `fwd_b` follows the same rules using `ex_rm`.
- Load-use hazard: `ex_load` and `ex_we` and `ex_rd` equals a used ID source.
- Branch: `ex_branch_taken`.
- Memory stall: `mem_req` and not `mem_rdy`.
- RUN priority, highest first:
  - Memory stall: every `_ld` = 0, `memwb_nop` = 1, next state MEM_WAIT, wait counter loads 1. A branch or load-use condition in the same cycle is ignored; it is re-evaluated after the wait.
  - Branch: `pc_src_br` = 1, `ifid_flush` = 1, `idex_nop` = 1, all `_ld` = 1. A concurrent load-use hazard is discarded.
  - Load-use: `pc_ld` = 0, `ifid_ld` = 0, `idex_nop` = 1; exactly one bubble.
  - Otherwise: all `_ld` = 1 and all bubbles = 0.
- MEM_WAIT:
  - Outputs are as for a memory stall.
  - When `mem_rdy` = 1, release that same cycle: outputs revert to RUN evaluation and next state is RUN.
  - Otherwise the counter increments. When it would reach `MEM_TIMEOUT`, next state is TRAP.
- TRAP: every `_ld` = 0, `mem_err` = 1. The only exit is `Reset`.
- `stall_cnt` increments on every cycle with `pc_ld` = 0 and saturates at all-ones.

## Timing
- Reset values: state RUN, wait counter 0, `stall_cnt` 0, `mem_err` 0. While `Reset` is asserted, all `_ld` = 0, all bubbles = 0, `pc_src_br` = 0 and `fwd_a`/`fwd_b` = 00.
- Control outputs are combinational from the current state and inputs, with zero latency. State, the counters and `mem_err` update on the rising `clk`.
- `Reset` asserted mid-MEM_WAIT or in TRAP returns to RUN immediately and asynchronously.
- `mem_rdy` arriving on the first `mem_req` cycle means no stall and no state change.
- Timeout boundary: with `MEM_TIMEOUT` = 15, the pipeline is frozen for 15 cycles; the 16th cycle is in TRAP.

## Structure
- Package `ppu_pkg`: state enumeration, forwarding-select constants (`FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`) and `PC_REG` = 15.
- One sub-module, `fwd_unit`: the combinational forwarding comparators, instantiated once per operand.

## Test plan
- Reset asserted at t=0 and released at t=1 → all `_ld` = 0 during reset. On the first clock with no hazard, all `_ld` = 1 and `stall_cnt` = 0.
- Load r3 in EX while ID reads `id_rn` = 3 → exactly one cycle of `pc_ld` = 0, `idex_nop` = 1; the next cycle is normal; `stall_cnt` = 1.
- `mem_we` with `mem_rd` = 2, `wb_we` with `wb_rd` = 2, `ex_rn` = 2 → `fwd_a` = 01. Same case with `mem_rd` = 15 → `fwd_a` = 10.
- Branch taken together with a load-use hazard → `pc_src_br` = 1, `ifid_flush` = 1, `pc_ld` = 1, no extra stall.
- `mem_req` with `mem_rdy` low for 3 cycles, then high → frozen for 3 cycles, released on the rdy cycle, `stall_cnt` = 3.
- `mem_rdy` held low with `MEM_TIMEOUT` = 15 → `mem_err` = 1 on the 16th cycle and held there. Pulsing `Reset` clears it back to RUN.
